// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
// Requests are a valid/ready handshake. Responses come back in order with
// no backpressure.
interface inst_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvld;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvld, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvld, imem_rdata
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// RV32I fetch front end.
// - Issues sequential fetches into an instruction buffer, throttled by credits.
// - Predecodes each response for static BTFN/JAL redirects.
// - Drops responses that belong to a squashed path, after a redirect or an ALU flush.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter bit          BTFN_EN    = 1'b1
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  inst_fetch_unit_if.master         imem,
  input  logic                      alu_flush,
  input  logic [31:0]               alu_flush_pc,
  input  logic                      nop_insert,
  input  logic                      lsu_ready,
  output logic [31:0]               inst,
  output logic [31:0]               inst_pc,
  output logic                      inst_taken,
  output logic                      inst_vld
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam int          CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] pc;
    logic        taken;
  } fq_ent_t;

  // Architectural fetch state.
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] out_q, out_d;     // requests accepted but not yet answered
  logic [CW-1:0] drop_q, drop_d;   // answers still owed to a squashed path

  // Instruction buffer.
  fq_ent_t       fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // PC queue: one entry per outstanding request, including squashed ones.
  // It is never flushed, so it stays aligned with the in-order responses.
  logic [31:0]   pq_q [FIFO_DEPTH];
  logic [AW-1:0] pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;

  logic          stall, pop, push, rsp, acc, pred, req;
  logic          is_jal, is_bwd;
  logic [31:0]   rd_w, rsp_pc, immj, immb, target;
  logic [CW:0]   occ;
  fq_ent_t       head, ent;

  // Decode-side view, predecode, and the issue decision.
  always_comb begin
    stall      = nop_insert | ~lsu_ready;
    head       = fifo_q[rd_q];
    inst_vld   = (cnt_q != '0);
    inst       = inst_vld ? head.rdata : NOP;
    inst_pc    = inst_vld ? head.pc    : 32'h0;
    inst_taken = inst_vld & head.taken;
    pop        = inst_vld & ~stall & ~alu_flush;

    rsp    = imem.imem_rvld;
    rd_w   = imem.imem_rdata;
    rsp_pc = pq_q[pq_rd_q];
    push   = rsp & ~alu_flush & (drop_q == '0);

    immj   = {{11{rd_w[31]}}, rd_w[31], rd_w[19:12], rd_w[20], rd_w[30:21], 1'b0};
    immb   = {{19{rd_w[31]}}, rd_w[31], rd_w[7], rd_w[30:25], rd_w[11:8], 1'b0};
    is_jal = (rd_w[6:0] == 7'b1101111);
    is_bwd = (rd_w[6:0] == 7'b1100011) & rd_w[31];
    pred   = BTFN_EN & push & (is_jal | is_bwd);
    target = (rsp_pc + (is_jal ? immj : immb)) & ~32'h3;

    ent.rdata = rd_w;
    ent.pc    = rsp_pc;
    ent.taken = pred;

    // Buffer entries plus in-flight requests must fit the buffer. A slot
    // freed by this cycle's pop can be reused at once.
    occ = {1'b0, cnt_q} + {1'b0, out_q} - {{CW{1'b0}}, pop};
    req = RSTN & ~alu_flush & ~pred & (occ < DEPTH_C);
    acc = req & imem.imem_ready;

    imem.imem_req  = req;
    imem.imem_addr = fetch_pc_q;
  end

  // Next-state logic. A flush overrides a redirect, and a redirect overrides sequential fetch.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q + CW'(acc) - CW'(rsp);
    drop_d     = drop_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    pq_wr_d    = acc ? pq_wr_q + AW'(1) : pq_wr_q;
    pq_rd_d    = rsp ? pq_rd_q + AW'(1) : pq_rd_q;

    if (alu_flush) begin
      fetch_pc_d = alu_flush_pc & ~32'h3;
      drop_d     = out_q - CW'(rsp);
      rd_d       = wr_q;
      cnt_d      = '0;
    end else begin
      if (pred) begin
        // Everything issued behind the taken instruction is on the wrong path.
        fetch_pc_d = target;
        drop_d     = out_q - CW'(1);
      end else if (acc) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp && drop_q != '0) drop_d = drop_q - CW'(1);
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Control registers, async reset.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      fetch_pc_q <= RESET_PC & ~32'h3;
      out_q      <= '0;
      drop_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      pq_wr_q    <= '0;
      pq_rd_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      pq_wr_q    <= pq_wr_d;
      pq_rd_q    <= pq_rd_d;
    end
  end

  // Data storage. No reset is needed, because valid bits are held in the counters.
  always_ff @(posedge CLK) begin
    if (push) fifo_q[wr_q]  <= ent;
    if (acc)  pq_q[pq_wr_q] <= fetch_pc_q;
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit.
// - Instance: FIFO_DEPTH=2, RESET_PC=0x100, BTFN on.
// - Memory responds one cycle after accept. It can hold its responses (resp_en=0).
module tb_inst_fetch_unit;
  logic        CLK, RSTN;
  logic        alu_flush, nop_insert, lsu_ready, resp_en;
  logic [31:0] alu_flush_pc;
  logic [31:0] inst, inst_pc;
  logic        inst_taken, inst_vld;
  int          n_vec, n_err;
  logic [31:0] acc_q[$], pc_q[$], tk_q[$], in_q[$], mq[$];

  inst_fetch_unit_if bus();

  inst_fetch_unit #(.RESET_PC(32'h100), .FIFO_DEPTH(2), .BTFN_EN(1'b1)) u_dut (
    .CLK(CLK), .RSTN(RSTN), .imem(bus),
    .alu_flush(alu_flush), .alu_flush_pc(alu_flush_pc),
    .nop_insert(nop_insert), .lsu_ready(lsu_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_taken(inst_taken), .inst_vld(inst_vld)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory image: three control-flow words, and an ADDI x1 tagged with addr[11:0] elsewhere.
  function automatic logic [31:0] mword(input logic [31:0] a);
    case (a)
      32'h200: return 32'hFE00_08E3;  // beq x0,x0,-16
      32'h300: return 32'h0200_0063;  // beq x0,x0,+32
      32'h400: return 32'h0800_006F;  // jal x0,+0x80
      default: return {a[11:0], 5'd0, 3'd0, 5'd1, 7'h13};
    endcase
  endfunction

  // In-order memory. The response is registered on the accept edge unless held.
  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mq.delete();
      bus.imem_rvld  <= 1'b0;
      bus.imem_rdata <= 32'h0;
    end else begin
      if (bus.imem_req && bus.imem_ready) mq.push_back(bus.imem_addr);
      if (resp_en && mq.size() > 0) begin
        bus.imem_rvld  <= 1'b1;
        bus.imem_rdata <= mword(mq.pop_front());
      end else begin
        bus.imem_rvld  <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qv(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic clr();
    acc_q.delete(); pc_q.delete(); tk_q.delete(); in_q.delete();
  endtask

  // Settle, then log this cycle's accepted address and consumed instruction.
  task automatic obs();
    #1;
    if (bus.imem_req && bus.imem_ready) acc_q.push_back(bus.imem_addr);
    if (inst_vld && lsu_ready && !nop_insert && !alu_flush) begin
      pc_q.push_back(inst_pc);
      tk_q.push_back({31'd0, inst_taken});
      in_q.push_back(inst);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic cyc();
    obs();
    nxt();
  endtask

  task automatic do_flush(input logic [31:0] pc);
    alu_flush = 1'b1; alu_flush_pc = pc;
    clr();
    obs();
    chk("flush_noreq", {31'd0, bus.imem_req}, 32'd0);
    nxt();
    alu_flush = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    RSTN = 1'b0; alu_flush = 1'b0; alu_flush_pc = 32'h0;
    nop_insert = 1'b0; lsu_ready = 1'b1; resp_en = 1'b1;
    bus.imem_ready = 1'b1;
    nxt(); nxt();

    // Reset state
    #1;
    chk("rst_req",   {31'd0, bus.imem_req}, 32'd0);
    chk("rst_vld",   {31'd0, inst_vld},     32'd0);
    chk("rst_inst",  inst,                  32'h0000_0013);
    chk("rst_pc",    inst_pc,               32'h0);
    chk("rst_taken", {31'd0, inst_taken},   32'd0);
    RSTN = 1'b1;

    // Start-up and steady stream
    obs(); chk("c0_req", {31'd0, bus.imem_req}, 32'd1); chk("c0_addr", bus.imem_addr, 32'h100); nxt();
    obs(); chk("c1_addr", bus.imem_addr, 32'h104); chk("c1_vld", {31'd0, inst_vld}, 32'd0); nxt();
    obs(); chk("c2_addr", bus.imem_addr, 32'h108); chk("c2_vld", {31'd0, inst_vld}, 32'd1);
           chk("c2_pc", inst_pc, 32'h100); chk("c2_inst", inst, 32'h1000_0093); nxt();
    obs(); chk("c3_pc", inst_pc, 32'h104); nxt();
    obs(); chk("c4_pc", inst_pc, 32'h108); chk("c4_addr", bus.imem_addr, 32'h110); nxt();

    // LSU busy for 5 cycles: the head freezes and issue stops at two in the pipe
    lsu_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      obs();
      chk("stall_pc",  inst_pc, 32'h10C);
      chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
      chk("stall_vld", {31'd0, inst_vld}, 32'd1);
      nxt();
    end
    lsu_ready = 1'b1;
    obs(); chk("rel_pc", inst_pc, 32'h10C); chk("rel_addr", bus.imem_addr, 32'h114); nxt();
    obs(); chk("rel_pc1", inst_pc, 32'h110); nxt();
    obs(); chk("rel_pc2", inst_pc, 32'h114); nxt();

    // Backward BEQ at 0x200. The 0x200 response is held one cycle so that 0x204 gets issued
    do_flush(32'h200);
    resp_en = 1'b0; cyc();
    resp_en = 1'b1; repeat (10) cyc();
    chk("bwd_acc0", qv(acc_q, 0), 32'h200);
    chk("bwd_acc1", qv(acc_q, 1), 32'h204);
    chk("bwd_acc2", qv(acc_q, 2), 32'h1F0);
    chk("bwd_pc0",  qv(pc_q, 0),  32'h200);
    chk("bwd_tk0",  qv(tk_q, 0),  32'd1);
    chk("bwd_in0",  qv(in_q, 0),  32'hFE00_08E3);
    chk("bwd_pc1",  qv(pc_q, 1),  32'h1F0);
    chk("bwd_tk1",  qv(tk_q, 1),  32'd0);
    chk("bwd_in1",  qv(in_q, 1),  32'h1F00_0093);
    chk("bwd_pc2",  qv(pc_q, 2),  32'h1F4);

    // Forward BEQ at 0x300 is not predicted
    do_flush(32'h300);
    repeat (6) cyc();
    chk("fwd_pc0",  qv(pc_q, 0),  32'h300);
    chk("fwd_tk0",  qv(tk_q, 0),  32'd0);
    chk("fwd_in0",  qv(in_q, 0),  32'h0200_0063);
    chk("fwd_pc1",  qv(pc_q, 1),  32'h304);
    chk("fwd_acc1", qv(acc_q, 1), 32'h304);

    // JAL at 0x400, +0x80
    do_flush(32'h400);
    repeat (10) cyc();
    chk("jal_pc0",  qv(pc_q, 0),  32'h400);
    chk("jal_tk0",  qv(tk_q, 0),  32'd1);
    chk("jal_pc1",  qv(pc_q, 1),  32'h480);
    chk("jal_tk1",  qv(tk_q, 1),  32'd0);
    chk("jal_acc1", qv(acc_q, 1), 32'h480);

    // Flush to 0x1003 with one entry buffered and one request held in memory
    resp_en = 1'b0; cyc();
    alu_flush = 1'b1; alu_flush_pc = 32'h1003; lsu_ready = 1'b0;
    clr(); obs();
    chk("fl_req", {31'd0, bus.imem_req}, 32'd0);
    chk("fl_vld_before", {31'd0, inst_vld}, 32'd1);
    nxt();
    alu_flush = 1'b0; lsu_ready = 1'b1; resp_en = 1'b1;
    obs();
    chk("fl_vld",  {31'd0, inst_vld}, 32'd0);
    chk("fl_addr", bus.imem_addr, 32'h1000);
    chk("fl_req1", {31'd0, bus.imem_req}, 32'd1);
    nxt();
    repeat (5) cyc();
    chk("fl_acc0", qv(acc_q, 0), 32'h1000);
    chk("fl_acc1", qv(acc_q, 1), 32'h1004);
    chk("fl_pc0",  qv(pc_q, 0),  32'h1000);
    chk("fl_pc1",  qv(pc_q, 1),  32'h1004);

    // A flush that coincides with a predicted-taken response and nop_insert wins
    do_flush(32'h200);
    cyc();
    alu_flush = 1'b1; alu_flush_pc = 32'h600; nop_insert = 1'b1;
    clr(); obs();
    chk("fp_rvld", {31'd0, bus.imem_rvld}, 32'd1);
    chk("fp_req",  {31'd0, bus.imem_req},  32'd0);
    nxt();
    alu_flush = 1'b0; nop_insert = 1'b0;
    obs();
    chk("fp_addr", bus.imem_addr, 32'h600);
    chk("fp_vld",  {31'd0, inst_vld}, 32'd0);
    nxt();
    repeat (5) cyc();
    chk("fp_acc0", qv(acc_q, 0), 32'h600);
    chk("fp_acc1", qv(acc_q, 1), 32'h604);
    chk("fp_pc0",  qv(pc_q, 0),  32'h600);
    chk("fp_tk0",  qv(tk_q, 0),  32'd0);

    // PC wrap, with an unaligned flush target
    do_flush(32'hFFFF_FFFE);
    repeat (6) cyc();
    chk("wrap_acc0", qv(acc_q, 0), 32'hFFFF_FFFC);
    chk("wrap_acc1", qv(acc_q, 1), 32'h0);
    chk("wrap_pc0",  qv(pc_q, 0),  32'hFFFF_FFFC);
    chk("wrap_pc1",  qv(pc_q, 1),  32'h0);

    // Asynchronous reset in the middle of operation
    chk("mid_vld_pre", {31'd0, inst_vld}, 32'd1);
    RSTN = 1'b0;
    #1;
    chk("mid_vld",  {31'd0, inst_vld},     32'd0);
    chk("mid_req",  {31'd0, bus.imem_req}, 32'd0);
    chk("mid_inst", inst,                  32'h0000_0013);
    chk("mid_pc",   inst_pc,               32'h0);
    nxt();
    RSTN = 1'b1;
    obs(); chk("mid_addr", bus.imem_addr, 32'h100); chk("mid_req1", {31'd0, bus.imem_req}, 32'd1);
    nxt();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
